// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - batch initiator for the greenhouse sequencer enable/done handshake
// Optional phase checking is built when IRRIGATION_SCHED_PHASE_CHECK_EN is defined.
module irrigation_scheduler #(
  parameter int NUM_PROFILES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int WD_SLACK     = 8,
  localparam int AW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    repeat_count,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_d1,
  input  logic [7:0]    cfg_d2,
  input  logic [7:0]    cfg_d3,
  input  logic          seq_done,
  input  logic          seq_irrigation,
  input  logic          seq_ventilation,
  output logic          seq_enable,
  output logic [7:0]    seq_d1,
  output logic [7:0]    seq_d2,
  output logic [7:0]    seq_d3,
  output logic          busy,
  output logic [7:0]    runs_done,
  output logic          finished,
  output logic          timeout_err,
  output logic          phase_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RELEASE,
    S_GAP,
    S_FINISH,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rep_q, rep_d;
  logic [7:0]    runs_q, runs_d;
  logic [9:0]    wd_q, wd_d;
  logic [9:0]    limit_q, limit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    sd1_q, sd1_d, sd2_q, sd2_d, sd3_q, sd3_d;
  logic          en_q, en_d;
  logic          fin_q, fin_d;
  logic          tout_q, tout_d;
  logic          clr_err;
  logic          in_batch;

  logic [7:0]    prof1_q [NUM_PROFILES];
  logic [7:0]    prof2_q [NUM_PROFILES];
  logic [7:0]    prof3_q [NUM_PROFILES];
  logic [AW-1:0] rd_sel;
  logic [7:0]    ld1, ld2, ld3;

  // The sequencer hangs on a zero duration, so zero is stored as one.
  function automatic logic [7:0] nz(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROFILES; i++) begin
        prof1_q[i] <= 8'd1;
        prof2_q[i] <= 8'd1;
        prof3_q[i] <= 8'd1;
      end
    end else begin
      for (int i = 0; i < NUM_PROFILES; i++) begin
        if (cfg_we && ((NUM_PROFILES == 1) || (cfg_addr == AW'(i)))) begin
          prof1_q[i] <= nz(cfg_d1);
          prof2_q[i] <= nz(cfg_d2);
          prof3_q[i] <= nz(cfg_d3);
        end
      end
    end
  end

  assign rd_sel = (NUM_PROFILES > 1) ? runs_q[AW-1:0] : '0;

  always_comb begin
    ld1 = 8'd1;
    ld2 = 8'd1;
    ld3 = 8'd1;
    for (int i = 0; i < NUM_PROFILES; i++) begin
      if (rd_sel == AW'(i)) begin
        ld1 = prof1_q[i];
        ld2 = prof2_q[i];
        ld3 = prof3_q[i];
      end
    end
  end

  assign in_batch = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_RELEASE) ||
                    (state_q == S_GAP)  || (state_q == S_FINISH);

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    runs_d  = runs_q;
    wd_d    = wd_q;
    limit_d = limit_q;
    gap_d   = gap_q;
    sd1_d   = sd1_q;
    sd2_d   = sd2_q;
    sd3_d   = sd3_q;
    fin_d   = 1'b0;
    tout_d  = tout_q;
    clr_err = 1'b0;
    en_d    = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start && !abort) begin
          if (repeat_count != 8'd0) begin
            rep_d   = repeat_count;
            runs_d  = 8'd0;
            tout_d  = 1'b0;
            clr_err = 1'b1;
            state_d = S_LOAD;
          end else begin
            fin_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        sd1_d   = ld1;
        sd2_d   = ld2;
        sd3_d   = ld3;
        limit_d = 10'(ld1) + 10'(ld2) + 10'(ld3) + 10'(WD_SLACK);
        wd_d    = 10'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A done in the same cycle as watchdog expiry still counts as a good run.
        if (seq_done) begin
          if (runs_q != 8'hFF) runs_d = runs_q + 8'd1;
          state_d = S_RELEASE;
        end else begin
          wd_d = wd_q + 10'd1;
          if (wd_d == limit_q) begin
            tout_d  = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_RELEASE: begin
        gap_d   = '0;
        state_d = (runs_q == rep_q) ? S_FINISH : S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_LOAD;
        else gap_d = gap_q + 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort && in_batch) begin
      state_d = S_IDLE;
      runs_d  = runs_q;
      tout_d  = tout_q;
      fin_d   = 1'b0;
    end

    if (state_d == S_FINISH) fin_d = 1'b1;
    en_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rep_q   <= 8'd0;
      runs_q  <= 8'd0;
      wd_q    <= 10'd0;
      limit_q <= 10'd0;
      gap_q   <= '0;
      sd1_q   <= 8'd0;
      sd2_q   <= 8'd0;
      sd3_q   <= 8'd0;
      en_q    <= 1'b0;
      fin_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      runs_q  <= runs_d;
      wd_q    <= wd_d;
      limit_q <= limit_d;
      gap_q   <= gap_d;
      sd1_q   <= sd1_d;
      sd2_q   <= sd2_d;
      sd3_q   <= sd3_d;
      en_q    <= en_d;
      fin_q   <= fin_d;
      tout_q  <= tout_d;
    end
  end

`ifdef IRRIGATION_SCHED_PHASE_CHECK_EN
  logic perr_q;
  logic irr_seen_q;
  logic phase_fault;

  assign phase_fault =
      (seq_irrigation && seq_ventilation) ||
      ((state_q == S_RUN) && seq_done && !irr_seen_q && !seq_irrigation) ||
      (seq_done && ((state_q == S_IDLE) || (state_q == S_GAP) || (state_q == S_LOAD)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q     <= 1'b0;
      irr_seen_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) irr_seen_q <= 1'b0;
      else if ((state_q == S_RUN) && seq_irrigation) irr_seen_q <= 1'b1;
      if (phase_fault) perr_q <= 1'b1;
      else if (clr_err) perr_q <= 1'b0;
    end
  end

  assign phase_err = perr_q;
`else
  logic unused_phase;
  assign unused_phase = &{1'b0, seq_irrigation, seq_ventilation, clr_err};
  assign phase_err    = 1'b0;
`endif

  assign seq_enable  = en_q;
  assign seq_d1      = sd1_q;
  assign seq_d2      = sd2_q;
  assign seq_d3      = sd3_q;
  assign busy        = in_batch;
  assign runs_done   = runs_q;
  assign finished    = fin_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - directed bench for irrigation_scheduler with a behavioural sequencer
module tb_irrigation_scheduler;

  logic       clk;
  logic       reset;
  logic       start, abort;
  logic [7:0] repeat_count;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_d1, cfg_d2, cfg_d3;
  logic       seq_done, seq_irrigation, seq_ventilation;
  logic       seq_enable;
  logic [7:0] seq_d1, seq_d2, seq_d3;
  logic       busy;
  logic [7:0] runs_done;
  logic       finished, timeout_err, phase_err;

  logic       model_en, force_irr, force_vent, clr;
  int         n_assert, n_fail;

`ifdef IRRIGATION_SCHED_PHASE_CHECK_EN
  localparam logic PH_EXP = 1'b1;
`else
  localparam logic PH_EXP = 1'b0;
`endif

  irrigation_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .repeat_count(repeat_count),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_d1(cfg_d1), .cfg_d2(cfg_d2), .cfg_d3(cfg_d3),
    .seq_done(seq_done), .seq_irrigation(seq_irrigation), .seq_ventilation(seq_ventilation),
    .seq_enable(seq_enable), .seq_d1(seq_d1), .seq_d2(seq_d2), .seq_d3(seq_d3),
    .busy(busy), .runs_done(runs_done), .finished(finished),
    .timeout_err(timeout_err), .phase_err(phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequencer: done on the (1+d1+d2+d3)th enable-high cycle, irrigation then ventilation.
  logic [9:0] sc;
  logic [9:0] sum;
  assign sum = 10'(seq_d1) + 10'(seq_d2) + 10'(seq_d3);
  always @(posedge clk or posedge reset) begin
    if (reset) sc <= 10'd0;
    else if (seq_enable) sc <= sc + 10'd1;
    else sc <= 10'd0;
  end
  assign seq_done = model_en && seq_enable && (sc == sum);
  assign seq_irrigation = (model_en && seq_enable && sc >= 10'd1 && sc <= 10'(seq_d1)) || force_irr;
  assign seq_ventilation = (model_en && seq_enable && sc > 10'(seq_d1) &&
                            sc <= 10'(seq_d1) + 10'(seq_d2)) || force_vent;

  int         hi_cnt, lo_cnt, fin_cnt;
  logic [2:0] nr;
  logic       prev_en;
  int         hlen [8];
  int         gaps [8];
  logic [7:0] rd1 [8];
  logic [7:0] rd2 [8];
  logic [7:0] rd3 [8];

  always @(negedge clk) begin
    if (clr) begin
      hi_cnt  <= 0;
      lo_cnt  <= 0;
      fin_cnt <= 0;
      nr      <= 3'd0;
      prev_en <= seq_enable;
    end else begin
      prev_en <= seq_enable;
      if (finished) fin_cnt <= fin_cnt + 1;
      if (seq_enable && !prev_en) begin
        rd1[nr]  <= seq_d1;
        rd2[nr]  <= seq_d2;
        rd3[nr]  <= seq_d3;
        gaps[nr] <= lo_cnt;
        hi_cnt   <= 1;
      end else if (seq_enable) begin
        hi_cnt <= hi_cnt + 1;
      end else if (prev_en) begin
        hlen[nr] <= hi_cnt;
        nr       <= nr + 3'd1;
        lo_cnt   <= 1;
      end else begin
        lo_cnt <= lo_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    cfg_addr = a; cfg_d1 = x; cfg_d2 = y; cfg_d3 = z; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic go(input logic [7:0] n);
    repeat_count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic ok;
    n_assert = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_count = 8'd0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_d1 = 8'd0; cfg_d2 = 8'd0; cfg_d3 = 8'd0;
    model_en = 1'b1; force_irr = 1'b0; force_vent = 1'b0; clr = 1'b1;
    tick(); tick();
    chk("rst_seq_enable", 32'(seq_enable), 32'd0);
    chk("rst_seq_d1", 32'(seq_d1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_runs_done", 32'(runs_done), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_phase", 32'(phase_err), 32'd0);
    reset = 1'b0; clr = 1'b0;
    tick();

    // Single run, profile {2,3,4}: enable high 1+2+3+4 cycles.
    wr(2'd0, 8'd2, 8'd3, 8'd4);
    clear_mon();
    go(8'd1);
    chk("t1_busy_load", 32'(busy), 32'd1);
    wait_idle("t1_done");
    chk("t1_runs", 32'(nr), 32'd1);
    chk("t1_enable_len", 32'(hlen[0]), 32'd10);
    chk("t1_d1", 32'(rd1[0]), 32'd2);
    chk("t1_d2", 32'(rd2[0]), 32'd3);
    chk("t1_d3", 32'(rd3[0]), 32'd4);
    chk("t1_runs_done", 32'(runs_done), 32'd1);
    chk("t1_finished_cnt", 32'(fin_cnt), 32'd1);
    chk("t1_timeout", 32'(timeout_err), 32'd0);

    // Three runs cycling profiles, zero duration stored as one.
    wr(2'd0, 8'd1, 8'd1, 8'd1);
    wr(2'd1, 8'd5, 8'd0, 8'd2);
    clear_mon();
    go(8'd3);
    wait_idle("t2_done");
    chk("t2_runs", 32'(nr), 32'd3);
    chk("t2_len0", 32'(hlen[0]), 32'd4);
    chk("t2_len1", 32'(hlen[1]), 32'd9);
    chk("t2_len2", 32'(hlen[2]), 32'd4);
    chk("t2_r1_d1", 32'(rd1[1]), 32'd5);
    chk("t2_r1_d2", 32'(rd2[1]), 32'd1);
    chk("t2_r1_d3", 32'(rd3[1]), 32'd2);
    chk("t2_r2_d1", 32'(rd1[2]), 32'd1);
    chk("t2_gap1", 32'(gaps[1]), 32'd6);
    chk("t2_gap2", 32'(gaps[2]), 32'd6);
    chk("t2_runs_done", 32'(runs_done), 32'd3);
    chk("t2_finished_cnt", 32'(fin_cnt), 32'd1);

    // Watchdog: no done, limit 1+1+1+8 = 11 RUN cycles.
    model_en = 1'b0;
    clear_mon();
    go(8'd1);
    wait_idle("t3_halt");
    chk("t3_enable_len", 32'(hlen[0]), 32'd11);
    chk("t3_timeout", 32'(timeout_err), 32'd1);
    chk("t3_enable", 32'(seq_enable), 32'd0);
    chk("t3_runs_done", 32'(runs_done), 32'd0);
    chk("t3_finished_cnt", 32'(fin_cnt), 32'd0);
    tick(); tick();
    chk("t3_timeout_held", 32'(timeout_err), 32'd1);
    model_en = 1'b1;
    clear_mon();
    go(8'd1);
    chk("t3_timeout_cleared", 32'(timeout_err), 32'd0);
    wait_idle("t3_rerun");
    chk("t3_rerun_runs_done", 32'(runs_done), 32'd1);
    chk("t3_rerun_finished", 32'(fin_cnt), 32'd1);

    // Abort on the 3rd RUN cycle of run 2 of 4.
    clear_mon();
    go(8'd4);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (nr == 3'd1 && seq_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_reach_run2", 32'(ok), 32'd1);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_enable", 32'(seq_enable), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_runs_done", 32'(runs_done), 32'd1);
    chk("t4_run2_len", 32'(hlen[1]), 32'd3);
    repeat (10) tick();
    chk("t4_no_finished", 32'(fin_cnt), 32'd0);
    chk("t4_still_idle", 32'(busy), 32'd0);

    // Zero repeat count: finished pulse only.
    clear_mon();
    go(8'd0);
    chk("t5_finished", 32'(finished), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    tick();
    chk("t5_finished_low", 32'(finished), 32'd0);
    repeat (5) tick();
    chk("t5_finished_cnt", 32'(fin_cnt), 32'd1);
    chk("t5_no_enable", 32'(nr), 32'd0);

    // Start while busy is ignored.
    clear_mon();
    go(8'd2);
    tick(); tick(); tick();
    go(8'd5);
    wait_idle("t6_done");
    chk("t6_runs_done", 32'(runs_done), 32'd2);
    chk("t6_runs", 32'(nr), 32'd2);
    chk("t6_finished_cnt", 32'(fin_cnt), 32'd1);

    // Abort beats start in IDLE.
    abort = 1'b1;
    go(8'd2);
    abort = 1'b0;
    chk("t7_busy", 32'(busy), 32'd0);
    tick();
    chk("t7_busy_after", 32'(busy), 32'd0);
    chk("t7_runs_done", 32'(runs_done), 32'd2);

    // Both phase indicators high for one cycle mid-run.
    clear_mon();
    go(8'd1);
    tick(); tick();
    force_irr = 1'b1; force_vent = 1'b1;
    tick();
    force_irr = 1'b0; force_vent = 1'b0;
    wait_idle("t8_done");
    chk("t8_phase_err", 32'(phase_err), 32'(PH_EXP));
    chk("t8_runs_done", 32'(runs_done), 32'd1);
    chk("t8_finished_cnt", 32'(fin_cnt), 32'd1);

    // Reset mid-run clears state and restores the profile table.
    go(8'd4);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("t9_busy", 32'(busy), 32'd0);
    chk("t9_enable", 32'(seq_enable), 32'd0);
    chk("t9_runs_done", 32'(runs_done), 32'd0);
    chk("t9_seq_d1", 32'(seq_d1), 32'd0);
    reset = 1'b0;
    tick();
    clear_mon();
    go(8'd2);
    wait_idle("t9_done");
    chk("t9_run2_len", 32'(hlen[1]), 32'd4);
    chk("t9_run2_d1", 32'(rd1[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
